lattice_bidir_pad_ctrl: RTL and testbench
=========================================

Name: lattice_bidir_pad_ctrl

Overview:
Fabric-side controller for one bidirectional pad, placed directly upstream of the BB/BBPU/BBPD bidirectional buffer. It registers the outgoing data and enable, inserts configurable bus-turnaround dead cycles between drive and release, and conditions the returning pad value. Conditioning covers synchronisation, debounce and rise/fall edge pulses. Its PAD_I, PAD_T and PAD_O ports connect one-to-one to the buffer's I, T and O.

Parameters:
SYNC_STAGES, 2, synchroniser depth on PAD_O; legal range 2..4.
DEBOUNCE_CYCLES, 4, consecutive stable cycles required before DIN changes; 1 = no filtering; legal range 1..255.
TURN_CYCLES, 1, dead cycles with pad released when switching direction; 0 = none; legal range 0..15.

Ports:
CLK  input  1  sole clock; all state updates on the rising edge.
RSTN  input  1  reset, asynchronous assert, active-low.
OE_REQ  input  1  1 = request to drive the pad.
DOUT  input  1  data to drive when driving.
PAD_O  input  1  raw pad value from buffer O; asynchronous to CLK.
PAD_I  output  1  registered drive data to buffer I.
PAD_T  output  1  registered tristate to buffer T; 1 = high-Z.
DRIVING  output  1  1 while the FSM is in DRIVE.
DIN  output  1  synchronised, debounced pad value.
RISE  output  1  one-cycle pulse when DIN changes 0->1.
FALL  output  1  one-cycle pulse when DIN changes 1->0.

Behaviour:
- Clock and reset: one clock (CLK); reset is asynchronous and active-low (RSTN).
- Reset values: PAD_T=1, PAD_I=0, DRIVING=0, DIN=0, RISE=0, FALL=0. Sync chain, debounce counter and turn counter are 0. FSM is in HIZ.
- All outputs are registered; no combinational input-to-output paths.
- Output FSM states and transitions:
  - HIZ: PAD_T=1. If OE_REQ=1, go to TURN_ON, or directly to DRIVE when TURN_CYCLES=0.
  - TURN_ON: PAD_T=1; turn counter counts TURN_CYCLES cycles, then goes to DRIVE. If OE_REQ=0 while here, go to HIZ immediately (abort).
  - DRIVE: PAD_T=0, DRIVING=1. If OE_REQ=0, go to TURN_OFF, or directly to HIZ when TURN_CYCLES=0.
  - TURN_OFF: PAD_T=1; counts TURN_CYCLES cycles, then goes to HIZ. OE_REQ is ignored here: release always completes, so reasserting OE_REQ re-enters TURN_ON only from HIZ.
- Output timing:
  - PAD_T and DRIVING are registered from the next state. With OE_REQ rising sampled at edge 0, PAD_T falls at edge 1+TURN_CYCLES.
  - With OE_REQ falling sampled at edge 0, PAD_T rises at edge 1.
- PAD_I <= DOUT on every edge, regardless of state (1-cycle latency), so data is valid before PAD_T falls.
- Input path:
  - PAD_O passes through a SYNC_STAGES flop chain; its output is S.
  - Counter rules: if S==DIN, counter <= 0. If S!=DIN and counter==DEBOUNCE_CYCLES-1, then DIN <= S and counter <= 0. Otherwise counter increments.
  - Any mismatch gap restarts the count.
  - Latency from PAD_O stable at sampling edge 0 to DIN change is SYNC_STAGES+DEBOUNCE_CYCLES edges (6 at defaults).
  - RISE/FALL assert in the same cycle DIN changes, for exactly one cycle.
- The input path runs in all FSM states, so loopback while driving is visible on DIN.
- Width rules:
  - Debounce counter is 8 bits; turn counter is 4 bits.
  - Out-of-range parameters are rejected by an elaboration-time check.
- Reset mid-operation: asserting RSTN low in any state forces PAD_T=1 asynchronously, releasing the pad without waiting for a clock.

Decomposition:
- Shared package: FSM state encoding (HIZ, TURN_ON, DRIVE, TURN_OFF), PAD_T_HIZ=1 / PAD_T_DRIVE=0 constants, and the parameter range limits.
- One sub-module, lattice_pad_in_filter: sync chain, debounce counter and edge pulses. Ports: CLK, RSTN, PAD_O, DIN, RISE, FALL.

Test Plan:
- Reset: hold RSTN=0 with OE_REQ=1 and DOUT=1 -> PAD_T=1, PAD_I=0, DIN=0, all pulses 0. First edge after release gives PAD_I=1.
- Drive handshake, TURN_CYCLES=2: OE_REQ=1 at edge 0 -> PAD_T=0 and DRIVING=1 from edge 3. OE_REQ=0 at edge 10 -> PAD_T=1 at edge 11, FSM in HIZ at edge 13.
- Abort and no-abort: OE_REQ pulsed 1 cycle in HIZ (TURN_CYCLES=2) -> PAD_T never 0. OE_REQ reasserted during TURN_OFF -> PAD_T stays 1 until HIZ is reached, then 2 more cycles elapse before drive resumes.
- Glitch rejection, defaults: PAD_O 0->1 for 3 cycles then back to 0 -> DIN stays 0, RISE never asserts.
- Stable edges, defaults: PAD_O 0->1 held -> DIN=1 and a single RISE pulse 6 edges later. PAD_O back to 0 -> single FALL pulse 6 edges later.
- Reset mid-drive: RSTN=0 between clock edges while in DRIVE -> PAD_T=1 immediately without a clock edge. After release, FSM is in HIZ and DIN=0.

Source files
------------

// File: rtl/lattice_bidir_pad_ctrl_pkg.sv
// Shared definitions for the bidirectional pad controller:
// FSM encoding, tristate polarity and parameter limits.
package lattice_bidir_pad_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_HIZ      = 2'd0,
      ST_TURN_ON  = 2'd1,
      ST_DRIVE    = 2'd2,
      ST_TURN_OFF = 2'd3
   } pad_state_e;

   localparam logic PAD_T_HIZ   = 1'b1;
   localparam logic PAD_T_DRIVE = 1'b0;

   localparam int SYNC_MIN = 2;
   localparam int SYNC_MAX = 4;
   localparam int DEB_MIN  = 1;
   localparam int DEB_MAX  = 255;
   localparam int TURN_MAX = 15;

endpackage

// File: rtl/lattice_pad_in_filter.sv
// Pad input conditioning: synchroniser, debounce filter
// and one-cycle rise/fall pulses aligned with DIN.
module lattice_pad_in_filter
   import lattice_bidir_pad_ctrl_pkg::*;
#(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic CLK,
   input  logic RSTN,
   input  logic PAD_O,
   output logic DIN,
   output logic RISE,
   output logic FALL
);

   localparam logic [7:0] DEB_LAST = 8'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic [7:0]             cnt_q, cnt_d;
   logic                   din_q, din_d;
   logic                   rise_q, rise_d;
   logic                   fall_q, fall_d;
   logic                   s;

   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], PAD_O};
      s      = sync_q[SYNC_STAGES-1];
      cnt_d  = cnt_q + 8'd1;
      din_d  = din_q;
      rise_d = 1'b0;
      fall_d = 1'b0;
      if (s == din_q) begin
         cnt_d = '0;
      end else if (cnt_q == DEB_LAST) begin
         // a full run of mismatches commits the new level
         din_d  = s;
         cnt_d  = '0;
         rise_d = s;
         fall_d = ~s;
      end
   end

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         sync_q <= '0;
         cnt_q  <= '0;
         din_q  <= 1'b0;
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         sync_q <= sync_d;
         cnt_q  <= cnt_d;
         din_q  <= din_d;
         rise_q <= rise_d;
         fall_q <= fall_d;
      end
   end

   assign DIN  = din_q;
   assign RISE = rise_q;
   assign FALL = fall_q;

endmodule

// File: rtl/lattice_bidir_pad_ctrl.sv
// Fabric-side controller for one BB/BBPU/BBPD pad: registered
// drive with turnaround dead cycles plus a conditioned input path.
module lattice_bidir_pad_ctrl
   import lattice_bidir_pad_ctrl_pkg::*;
#(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int TURN_CYCLES     = 1
) (
   input  logic CLK,
   input  logic RSTN,
   input  logic OE_REQ,
   input  logic DOUT,
   input  logic PAD_O,
   output logic PAD_I,
   output logic PAD_T,
   output logic DRIVING,
   output logic DIN,
   output logic RISE,
   output logic FALL
);

   if (SYNC_STAGES < SYNC_MIN || SYNC_STAGES > SYNC_MAX) begin : g_bad_sync
      $error("SYNC_STAGES out of range");
   end
   if (DEBOUNCE_CYCLES < DEB_MIN || DEBOUNCE_CYCLES > DEB_MAX) begin : g_bad_deb
      $error("DEBOUNCE_CYCLES out of range");
   end
   if (TURN_CYCLES < 0 || TURN_CYCLES > TURN_MAX) begin : g_bad_turn
      $error("TURN_CYCLES out of range");
   end

   localparam logic [3:0] TURN_LAST =
      (TURN_CYCLES == 0) ? 4'd0 : 4'(TURN_CYCLES - 1);

   pad_state_e state_q, state_d;
   logic [3:0] turn_q, turn_d;
   logic       pad_t_q, pad_t_d;
   logic       driving_q, driving_d;
   logic       pad_i_q, pad_i_d;

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         state_q   <= ST_HIZ;
         turn_q    <= '0;
         pad_t_q   <= PAD_T_HIZ;
         driving_q <= 1'b0;
         pad_i_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         turn_q    <= turn_d;
         pad_t_q   <= pad_t_d;
         driving_q <= driving_d;
         pad_i_q   <= pad_i_d;
      end
   end

   always_comb begin
      state_d = state_q;
      turn_d  = turn_q;
      unique case (state_q)
         ST_HIZ: begin
            if (OE_REQ) begin
               turn_d  = '0;
               state_d = (TURN_CYCLES == 0) ? ST_DRIVE : ST_TURN_ON;
            end
         end
         ST_TURN_ON: begin
            if (!OE_REQ) begin
               state_d = ST_HIZ;
            end else if (turn_q == TURN_LAST) begin
               state_d = ST_DRIVE;
            end else begin
               turn_d = turn_q + 4'd1;
            end
         end
         ST_DRIVE: begin
            if (!OE_REQ) begin
               turn_d  = '0;
               state_d = (TURN_CYCLES == 0) ? ST_HIZ : ST_TURN_OFF;
            end
         end
         ST_TURN_OFF: begin
            // release always runs to completion
            if (turn_q == TURN_LAST) begin
               state_d = ST_HIZ;
            end else begin
               turn_d = turn_q + 4'd1;
            end
         end
         default: state_d = ST_HIZ;
      endcase
   end

   always_comb begin
      pad_t_d   = (state_d == ST_DRIVE) ? PAD_T_DRIVE : PAD_T_HIZ;
      driving_d = (state_d == ST_DRIVE);
      pad_i_d   = DOUT;
   end

   assign PAD_T   = pad_t_q;
   assign DRIVING = driving_q;
   assign PAD_I   = pad_i_q;

   lattice_pad_in_filter #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_in_filter (
      .CLK  (CLK),
      .RSTN (RSTN),
      .PAD_O(PAD_O),
      .DIN  (DIN),
      .RISE (RISE),
      .FALL (FALL)
   );

endmodule

// File: tb/tb_lattice_bidir_pad_ctrl.sv
// Directed bench for lattice_bidir_pad_ctrl with a cycle-level
// behavioural model compared on every falling clock edge.
module tb_lattice_bidir_pad_ctrl;

   localparam int SYNC = 2;
   localparam int DEB  = 4;
   localparam int TURN = 2;

   logic clk = 1'b0;
   logic rst_n, oe, dout, pad_o;
   logic pad_i, pad_t, driving, din, rise, fall;

   int checks = 0;
   int errors = 0;

   lattice_bidir_pad_ctrl #(
      .SYNC_STAGES    (SYNC),
      .DEBOUNCE_CYCLES(DEB),
      .TURN_CYCLES    (TURN)
   ) dut (
      .CLK    (clk),
      .RSTN   (rst_n),
      .OE_REQ (oe),
      .DOUT   (dout),
      .PAD_O  (pad_o),
      .PAD_I  (pad_i),
      .PAD_T  (pad_t),
      .DRIVING(driving),
      .DIN    (din),
      .RISE   (rise),
      .FALL   (fall)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // model: drive mode flag, dead-time countdown, sliding window on S
   bit m_drv, m_pad_i, m_din, m_rise, m_fall;
   int m_on_run, m_rel_left;
   bit pq[$];
   bit win[$];

   task automatic m_reset();
      m_drv = 0; m_pad_i = 0; m_din = 0; m_rise = 0; m_fall = 0;
      m_on_run = 0; m_rel_left = 0;
      pq.delete();
      win.delete();
      for (int i = 0; i < SYNC; i++) pq.push_back(1'b0);
      for (int i = 0; i < DEB; i++) win.push_back(1'b0);
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_reset();
      end else begin
         bit s, all_diff;
         m_pad_i = dout;
         if (m_rel_left > 0) begin
            m_rel_left--;
            m_on_run = 0;
         end else if (m_drv) begin
            if (!oe) begin
               m_drv = 0;
               m_rel_left = TURN;
            end
         end else if (oe) begin
            m_on_run++;
            if (m_on_run > TURN) begin
               m_drv = 1;
               m_on_run = 0;
            end
         end else begin
            m_on_run = 0;
         end
         s = pq.pop_front();
         pq.push_back(pad_o);
         win.push_back(s);
         if (win.size() > DEB) void'(win.pop_front());
         all_diff = 1;
         foreach (win[i]) if (win[i] == m_din) all_diff = 0;
         m_rise = 0;
         m_fall = 0;
         if (all_diff) begin
            m_din  = ~m_din;
            m_rise = m_din;
            m_fall = ~m_din;
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         chk("cyc_pad_t", pad_t, ~m_drv);
         chk("cyc_driving", driving, m_drv);
         chk("cyc_pad_i", pad_i, m_pad_i);
         chk("cyc_din", din, m_din);
         chk("cyc_rise", rise, m_rise);
         chk("cyc_fall", fall, m_fall);
      end
   end

   initial begin
      logic seen;
      rst_n = 0; oe = 1; dout = 1; pad_o = 0;
      tick(3);
      chk("rst_pad_t", pad_t, 1'b1);
      chk("rst_pad_i", pad_i, 1'b0);
      chk("rst_driving", driving, 1'b0);
      chk("rst_din", din, 1'b0);
      chk("rst_rise", rise, 1'b0);
      chk("rst_fall", fall, 1'b0);
      rst_n = 1;
      tick(1);
      chk("rst_first_pad_i", pad_i, 1'b1);
      oe = 0; dout = 0;
      tick(3);

      // drive handshake
      oe = 1; dout = 1;
      tick(2);
      chk("hs_e2_pad_t", pad_t, 1'b1);
      tick(1);
      chk("hs_e3_pad_t", pad_t, 1'b0);
      chk("hs_e3_driving", driving, 1'b1);
      dout = 0;
      tick(7);
      oe = 0;
      tick(1);
      chk("hs_e11_pad_t", pad_t, 1'b1);
      chk("hs_e11_driving", driving, 1'b0);
      tick(2);

      // abort: one-cycle request never drives
      oe = 1;
      tick(1);
      oe = 0;
      seen = 0;
      for (int i = 0; i < 5; i++) begin
         tick(1);
         seen = seen | ~pad_t;
      end
      chk("abort_never_drive", seen, 1'b0);

      // no abort of release: re-request during TURN_OFF
      oe = 1;
      tick(3);
      chk("na_drive", pad_t, 1'b0);
      oe = 0;
      tick(1);
      oe = 1;
      tick(4);
      chk("na_e5_pad_t", pad_t, 1'b1);
      tick(1);
      chk("na_e6_pad_t", pad_t, 1'b0);
      oe = 0;
      tick(3);

      // glitch rejection
      pad_o = 1;
      tick(3);
      pad_o = 0;
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         tick(1);
         seen = seen | din | rise;
      end
      chk("glitch_reject", seen, 1'b0);

      // stable rise then fall
      pad_o = 1;
      tick(5);
      chk("rise_e5_din", din, 1'b0);
      tick(1);
      chk("rise_e6_din", din, 1'b1);
      chk("rise_e6_pulse", rise, 1'b1);
      tick(1);
      chk("rise_e7_pulse", rise, 1'b0);
      tick(2);
      pad_o = 0;
      tick(5);
      chk("fall_e5_din", din, 1'b1);
      tick(1);
      chk("fall_e6_din", din, 1'b0);
      chk("fall_e6_pulse", fall, 1'b1);
      tick(1);
      chk("fall_e7_pulse", fall, 1'b0);
      tick(2);

      // asynchronous reset while driving
      pad_o = 1; oe = 1;
      tick(8);
      chk("mid_pre_driving", driving, 1'b1);
      chk("mid_pre_din", din, 1'b1);
      #2;
      rst_n = 0;
      #1;
      chk("mid_async_pad_t", pad_t, 1'b1);
      chk("mid_async_driving", driving, 1'b0);
      chk("mid_async_din", din, 1'b0);
      oe = 0; pad_o = 0;
      tick(1);
      rst_n = 1;
      tick(3);
      chk("mid_post_pad_t", pad_t, 1'b1);
      chk("mid_post_driving", driving, 1'b0);
      chk("mid_post_din", din, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
